// File: rtl/pe_pkg.sv
// Shared PE constants and types: coefficient width, Kyber/Dilithium moduli, mode enum.
package pe_pkg;
  localparam int COEF_W  = 23;
  localparam int KYBER_W = 12;
  localparam logic [11:0] KYBER_Q     = 12'd3329;
  localparam logic [22:0] DILITHIUM_Q = 23'd8380417;

  typedef logic [COEF_W-1:0] coef_t;
  typedef enum logic {MODE_DILITHIUM = 1'b0, MODE_KYBER = 1'b1} mode_e;
endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiplier: c = a*b mod q, q selected per operation.
module mod_mul
  import pe_pkg::*;
(
  input  coef_t a_i,
  input  coef_t b_i,
  input  logic  select_i,
  output coef_t c_o
);
  logic [2*COEF_W-1:0] prod;

  always_comb begin
    prod = a_i * b_i;
    if (select_i) c_o = COEF_W'(prod % (2*COEF_W)'(KYBER_Q));
    else          c_o = COEF_W'(prod % (2*COEF_W)'(DILITHIUM_Q));
  end
endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping.
module rr_grant #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);
  logic found;
  int   j;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[IW'(j)]) begin
        found            = 1'b1;
        grant_o[IW'(j)]  = 1'b1;
        grant_idx_o      = IW'(j);
      end
    end
  end
endmodule

// File: rtl/mod_mul_arbiter.sv
// Round-robin arbiter sharing one mod_mul among NREQ requesters through a 2-stage pipeline.
module mod_mul_arbiter
  import pe_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int COEF_W = pe_pkg::COEF_W,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ*COEF_W-1:0] req_a_i,
  input  logic [NREQ*COEF_W-1:0] req_b_i,
  input  logic [NREQ-1:0]        req_sel_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [COEF_W-1:0]      rsp_c_o,
  output logic                   busy_o
);
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] gidx, ptr_q, ptr_d;
  logic            advance, s1_load, hs;
  coef_t           ga, gb, mm_c;
  logic            gsel;

  logic            s1_v_q;
  coef_t           s1_a_q, s1_b_q;
  mode_e           s1_sel_q;
  logic [ID_W-1:0] s1_id_q;

  logic            rsp_v_q;
  logic [ID_W-1:0] rsp_id_q;
  coef_t           rsp_c_q;

  rr_grant #(.N(NREQ)) u_rr (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (gidx)
  );

  assign advance     = !rsp_v_q | rsp_ready_i;
  assign s1_load     = !s1_v_q | advance;
  assign req_ready_o = s1_load ? grant : '0;
  assign hs          = |req_ready_o;

  // Kyber operands live in the low 12 bits; upper bits are cleared on capture.
  always_comb begin
    gsel = req_sel_i[gidx];
    ga   = req_a_i[int'(gidx)*COEF_W +: COEF_W];
    gb   = req_b_i[int'(gidx)*COEF_W +: COEF_W];
    if (gsel) begin
      ga = {(COEF_W-KYBER_W)'(0), ga[KYBER_W-1:0]};
      gb = {(COEF_W-KYBER_W)'(0), gb[KYBER_W-1:0]};
    end
    ptr_d = ptr_q;
    if (hs) ptr_d = (gidx == ID_W'(NREQ-1)) ? '0 : gidx + 1'b1;
  end

  mod_mul u_mul (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .select_i (s1_sel_q == MODE_KYBER),
    .c_o      (mm_c)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      s1_v_q   <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_sel_q <= MODE_DILITHIUM;
      s1_id_q  <= '0;
      rsp_v_q  <= 1'b0;
      rsp_id_q <= '0;
      rsp_c_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (advance) begin
        rsp_v_q <= s1_v_q;
        if (s1_v_q) begin
          rsp_id_q <= s1_id_q;
          rsp_c_q  <= mm_c;
        end
      end
      if (s1_load) begin
        s1_v_q <= hs;
        if (hs) begin
          s1_a_q   <= ga;
          s1_b_q   <= gb;
          s1_sel_q <= mode_e'(gsel);
          s1_id_q  <= gidx;
        end
      end
    end
  end

  assign rsp_valid_o = rsp_v_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_c_o     = rsp_c_q;
  assign busy_o      = s1_v_q | rsp_v_q;
endmodule
